// File: rtl/sprite_load_if.sv
// sprite_load_if: valid/ready teleport request carrying the target sprite position.
interface sprite_load_if;
  logic        load_valid_in;
  logic [10:0] load_x_in;
  logic [9:0]  load_y_in;
  logic        load_ready_out;
  modport master (output load_valid_in, load_x_in, load_y_in, input load_ready_out);
  modport slave (input load_valid_in, load_x_in, load_y_in, output load_ready_out);
endinterface

// File: rtl/sprite_mover.sv
// sprite_mover: per-frame sprite position update that bounces off the screen edges, with a teleport load port.
// Define SPRITE_WRAP_EN to make the axes wrap around the screen instead of bouncing.
module sprite_mover #(
  parameter int SCREEN_W  = 1280,
  parameter int SCREEN_H  = 720,
  parameter int WIDTH     = 256,
  parameter int HEIGHT    = 256,
  parameter int SPEED_X   = 2,
  parameter int SPEED_Y   = 1,
  parameter int INIT_X    = 0,
  parameter int INIT_Y    = 0,
  parameter int FRAME_DIV = 1
) (
  input  logic         pixel_clk_in,
  input  logic         rst_n_in,
  input  logic         new_frame_in,
  input  logic         run_in,
  sprite_load_if.slave load,
  output logic [10:0]  x_out,
  output logic [9:0]   y_out,
  output logic         dir_x_out,
  output logic         dir_y_out,
  output logic         bounce_out
);
  localparam logic signed [11:0] MAX_X = 12'(SCREEN_W - WIDTH);
  localparam logic signed [10:0] MAX_Y = 11'(SCREEN_H - HEIGHT);
  localparam logic signed [11:0] SPD_X = 12'(SPEED_X);
  localparam logic signed [10:0] SPD_Y = 11'(SPEED_Y);
  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);
  typedef enum logic [1:0] {IDLE, STEP_X, STEP_Y, COMMIT} state_t;
  state_t state;
  logic [7:0] div;
  logic [10:0] nx_q, clamp_x;
  logic [9:0] ny_q, clamp_y;
  logic ndx_q, ndy_q, hit_x_q, hit_y_q;
  logic signed [11:0] sx, nx;
  logic signed [10:0] sy, ny;
  logic hit_x, hit_y, ndx, ndy;
  assign sx = dir_x_out ? $signed({1'b0, x_out}) - SPD_X : $signed({1'b0, x_out}) + SPD_X;
  assign sy = dir_y_out ? $signed({1'b0, y_out}) - SPD_Y : $signed({1'b0, y_out}) + SPD_Y;
`ifdef SPRITE_WRAP_EN
  assign hit_x = sx > MAX_X || sx < 12'sd0;
  assign nx = sx > MAX_X ? sx - MAX_X - 12'sd1 : sx < 12'sd0 ? sx + MAX_X + 12'sd1 : sx;
  assign ndx = dir_x_out;
  assign hit_y = sy > MAX_Y || sy < 11'sd0;
  assign ny = sy > MAX_Y ? sy - MAX_Y - 11'sd1 : sy < 11'sd0 ? sy + MAX_Y + 11'sd1 : sy;
  assign ndy = dir_y_out;
`else
  assign hit_x = dir_x_out ? sx <= 12'sd0 : sx >= MAX_X;
  assign nx = hit_x ? (dir_x_out ? 12'sd0 : MAX_X) : sx;
  assign ndx = dir_x_out ^ hit_x;
  assign hit_y = dir_y_out ? sy <= 11'sd0 : sy >= MAX_Y;
  assign ny = hit_y ? (dir_y_out ? 11'sd0 : MAX_Y) : sy;
  assign ndy = dir_y_out ^ hit_y;
`endif
  assign clamp_x = load.load_x_in > 11'(MAX_X) ? 11'(MAX_X) : load.load_x_in;
  assign clamp_y = load.load_y_in > 10'(MAX_Y) ? 10'(MAX_Y) : load.load_y_in;
  assign load.load_ready_out = state == IDLE;
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
      div <= '0;
      x_out <= 11'(INIT_X);
      y_out <= 10'(INIT_Y);
      dir_x_out <= 1'b0;
      dir_y_out <= 1'b0;
      bounce_out <= 1'b0;
      nx_q <= '0;
      ny_q <= '0;
      ndx_q <= 1'b0;
      ndy_q <= 1'b0;
      hit_x_q <= 1'b0;
      hit_y_q <= 1'b0;
    end else begin
      bounce_out <= 1'b0;
      case (state)
        IDLE: begin
          if (new_frame_in) div <= div == DIV_LAST ? '0 : div + 8'd1;
          // a pending load takes priority over a due step in the same cycle
          if (load.load_valid_in) begin
            x_out <= clamp_x;
            y_out <= clamp_y;
          end else if (new_frame_in && run_in && div == DIV_LAST) state <= STEP_X;
        end
        STEP_X: begin
          nx_q <= 11'(nx);
          ndx_q <= ndx;
          hit_x_q <= hit_x;
          state <= STEP_Y;
        end
        STEP_Y: begin
          ny_q <= 10'(ny);
          ndy_q <= ndy;
          hit_y_q <= hit_y;
          state <= COMMIT;
        end
        COMMIT: begin
          x_out <= nx_q;
          y_out <= ny_q;
          dir_x_out <= ndx_q;
          dir_y_out <= ndy_q;
          bounce_out <= hit_x_q | hit_y_q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/sprite_mover.md
# sprite_mover

Per-frame position controller for one sprite on the 1280x720 display. Produces the sprite's top-left `x`/`y` coordinates consumed by the sprite renderer's position inputs. Once per (divided) frame, at the start of vertical blank, it advances the position by a fixed velocity and bounces off screen edges. Accepts an asynchronous "teleport" load through a valid/ready handshake.

## Interface
Parameters:
- `SCREEN_W`, 1280: active width in pixels.
- `SCREEN_H`, 720: active height in pixels.
- `WIDTH`, 256: sprite width. Must satisfy `WIDTH <= SCREEN_W`.
- `HEIGHT`, 256: sprite height. Must satisfy `HEIGHT <= SCREEN_H`.
- `SPEED_X`, 2: x step per update, unsigned, 1..63.
- `SPEED_Y`, 1: y step per update, unsigned, 1..63.
- `INIT_X`, 0: reset x.
- `INIT_Y`, 0: reset y.
- `FRAME_DIV`, 1: update once every `FRAME_DIV` frame pulses, 1..255.

Ports:
- `pixel_clk_in`  in  1: the single clock.
- `rst_n_in`  in  1: asynchronous, active-low reset.
- `new_frame_in`  in  1: one-cycle pulse at the start of vertical blank (hcount=0, vcount=SCREEN_H).
- `run_in`  in  1: motion enable, sampled on `new_frame_in`.
- `load_valid_in`  in  1: load request.
- `load_x_in`  in  11: requested x.
- `load_y_in`  in  10: requested y.
- `load_ready_out`  out  1: high in IDLE only.
- `x_out`  out  11: sprite left x.
- `y_out`  out  10: sprite top y.
- `dir_x_out`  out  1: 1 means x is moving negative.
- `dir_y_out`  out  1: 1 means y is moving negative.
- `bounce_out`  out  1: one-cycle pulse when either axis hit an edge in this update.

## Operation
- Limits: `MAX_X = SCREEN_W-WIDTH` and `MAX_Y = SCREEN_H-HEIGHT`. Both `x_out` and `y_out` always lie within [0, MAX].
- FSM states: IDLE → STEP_X → STEP_Y → COMMIT → IDLE. One cycle each, except IDLE.
- **IDLE behaviour:**
  - `new_frame_in` increments the divider.
  - If the divider reaches `FRAME_DIV-1`, the divider clears to 0.
  - If, in addition, `run_in`=1, go to STEP_X. Otherwise stay in IDLE.
- **STEP_X:**
  - Compute `nx = x ± SPEED_X` in 12-bit signed. The sign comes from `dir_x`.
  - If `nx >= MAX_X` while moving positive: next x = MAX_X, flip dir_x, set the bounce flag.
  - If `nx <= 0` while moving negative: next x = 0, flip dir_x, set the bounce flag.
  - Otherwise next x = nx.
- **STEP_Y:** same rule with `SPEED_Y`, `MAX_Y`, `dir_y` and 11-bit signed arithmetic.
- **COMMIT:**
  - Write the next x and next y to `x_out`/`y_out` together, so they are never torn.
  - Update the direction bits.
  - `bounce_out` pulses high for exactly one cycle if either axis flipped.
- **Load:**
  - A transfer occurs when `load_valid_in && load_ready_out`.
  - Clamp `x_out = min(load_x_in, MAX_X)` and `y_out = min(load_y_in, MAX_Y)`.
  - Directions are unchanged. No bounce pulse.
- Load and `new_frame_in` in the same IDLE cycle: the load wins and the step is skipped. The divider still counts.
- `new_frame_in` outside IDLE: ignored, and the divider does not count.
- `load_valid_in` outside IDLE: not accepted. The requester holds it until ready.

## Timing
- Reset values, applied asynchronously on `rst_n_in`=0:
  - `x_out=INIT_X`, `y_out=INIT_Y`.
  - `dir_x_out=0`, `dir_y_out=0`, `bounce_out=0`.
  - `load_ready_out=1`.
  - State IDLE, divider 0.
- Reset mid-update (STEP_X, STEP_Y or COMMIT) aborts the update. No partial commit.
- Frame update latency: `new_frame_in` sampled high in cycle N → new `x_out`/`y_out`/`dir_*` and `bounce_out` first visible in cycle N+4. `bounce_out` is low again in N+5.
- `load_ready_out` is low in cycles N+1..N+3 of an update.
- Load latency: handshake in cycle N → clamped position visible in N+1.
- All outputs are registered. There are no combinational paths from inputs to outputs except none. `load_ready_out` is decoded from the state register only.

## Configuration
- Macro `SPRITE_WRAP_EN`.
- **Defined:** axes wrap instead of bouncing.
  - `nx > MAX_X` → `nx-(MAX_X+1)`.
  - `nx < 0` → `nx+(MAX_X+1)`. Same rule for y.
  - Directions never flip.
  - `bounce_out` pulses on a wrap.
- **Undefined:** bounce/clamp behaviour as described in Operation.

## Test plan
- **Reset then single step.** Release reset; frame pulse with `run_in`=1 → x=2, y=1 appear exactly in cycle N+4. `bounce_out`=0.
- **Edge bounce.**
  - Load (1023,463), then frame → x=1024, y=464, `dir_x_out`=1, `dir_y_out`=1, `bounce_out` is a one-cycle pulse.
  - Next frame → x=1022, y=463, no bounce.
- **Load clamp and collision.**
  - Load (2000,900) → (1024,464) in the next cycle.
  - Load (10,10) in the same cycle as a frame pulse → (10,10), no step applied.
- **Enable and divider.**
  - `run_in`=0 across 5 pulses → position unchanged.
  - With `FRAME_DIV`=3 and run=1, 6 pulses → exactly 2 steps, committed after pulses 3 and 6.
- **Reset mid-operation.** Assert `rst_n_in` low during STEP_Y → outputs return to INIT immediately. After release, no stale commit or bounce pulse.
- **`SPRITE_WRAP_EN` build.** Load (1023,0), frame → x=0, y=1, `dir_x_out`=0, `bounce_out` pulses.
